alu_issue_arbiter: RTL and testbench

ALU_ISSUE_ARBITER -- requirements
Module: alu_issue_arbiter

---
 rtl/alu_issue_arbiter.sv | 147 ++++++++++++++
 tb/tb_alu_issue_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_arbiter.sv
// Two-slot round-robin issue arbiter sharing one ALU, with a single
// registered result stage and valid/ready handshakes on both sides.

module alu_issue_alu (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic [3:0]  f_i,
  input  logic [4:0]  shamt_i,
  output logic [31:0] y_o,
  output logic        err_o
);

  logic [31:0] diff;

  assign diff = a_i + ~b_i + 32'd1;

  // Unlisted function codes produce zero and flag an error.
  always_comb begin
    y_o   = '0;
    err_o = 1'b0;
    unique case (f_i)
      4'b0000: y_o = a_i & b_i;
      4'b0001: y_o = a_i | b_i;
      4'b0010: y_o = a_i + b_i;
      4'b1010: y_o = diff;
      4'b1011: y_o = {31'd0, diff[31]};
      4'b0100: y_o = b_i << shamt_i;
      default: err_o = 1'b1;
    endcase
  end

endmodule

module alu_issue_arbiter #(
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [3:0]       req0_f,
  input  logic [4:0]       req0_shamt,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [3:0]       req1_f,
  input  logic [4:0]       req1_shamt,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_y,
  output logic [TAG_W-1:0] res_tag,
  output logic             res_src,
  output logic             res_err
);

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned FUNC_W  = 4;
  localparam int unsigned SHAMT_W = 5;

  logic               res_valid_q, res_valid_d;
  logic [DATA_W-1:0]  res_y_q, res_y_d;
  logic [TAG_W-1:0]   res_tag_q, res_tag_d;
  logic               res_src_q, res_src_d;
  logic               res_err_q, res_err_d;
  logic               ptr_q, ptr_d;

  logic               can_accept;
  logic               sel;
  logic               accept;
  logic [DATA_W-1:0]  op_a, op_b, alu_y;
  logic [FUNC_W-1:0]  op_f;
  logic [SHAMT_W-1:0] op_shamt;
  logic [TAG_W-1:0]   op_tag;
  logic               alu_err;

  // The pointer only matters on contention; a lone requester wins outright.
  assign can_accept = !res_valid_q | res_ready;
  assign sel        = (req0_valid & req1_valid) ? ptr_q : req1_valid;
  assign accept     = !reset & can_accept & (req0_valid | req1_valid);
  assign req0_ready = accept & !sel;
  assign req1_ready = accept & sel;

  assign op_a     = sel ? req1_a     : req0_a;
  assign op_b     = sel ? req1_b     : req0_b;
  assign op_f     = sel ? req1_f     : req0_f;
  assign op_shamt = sel ? req1_shamt : req0_shamt;
  assign op_tag   = sel ? req1_tag   : req0_tag;

  alu_issue_alu u_alu (
    .a_i     (op_a),
    .b_i     (op_b),
    .f_i     (op_f),
    .shamt_i (op_shamt),
    .y_o     (alu_y),
    .err_o   (alu_err)
  );

  // Result stage: load on accept, otherwise drain clears only the valid flag.
  always_comb begin
    res_valid_d = res_valid_q;
    res_y_d     = res_y_q;
    res_tag_d   = res_tag_q;
    res_src_d   = res_src_q;
    res_err_d   = res_err_q;
    ptr_d       = ptr_q;
    if (accept) begin
      res_valid_d = 1'b1;
      res_y_d     = alu_y;
      res_tag_d   = op_tag;
      res_src_d   = sel;
      res_err_d   = alu_err;
      ptr_d       = !sel;
    end else if (res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_valid_q <= 1'b0;
      res_y_q     <= '0;
      res_tag_q   <= '0;
      res_src_q   <= 1'b0;
      res_err_q   <= 1'b0;
      ptr_q       <= 1'b0;
    end else begin
      res_valid_q <= res_valid_d;
      res_y_q     <= res_y_d;
      res_tag_q   <= res_tag_d;
      res_src_q   <= res_src_d;
      res_err_q   <= res_err_d;
      ptr_q       <= ptr_d;
    end
  end

  assign res_valid = res_valid_q;
  assign res_y     = res_y_q;
  assign res_tag   = res_tag_q;
  assign res_src   = res_src_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_alu_issue_arbiter.sv
// Bench for alu_issue_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of arbitration and ALU results.

module tb_alu_issue_arbiter;

  localparam int unsigned TAG_W = 4;

  logic clk = 1'b0;
  logic reset;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_f, req1_f;
  logic [4:0]  req0_shamt, req1_shamt;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic res_valid, res_ready, res_src, res_err;
  logic [31:0] res_y;
  logic [TAG_W-1:0] res_tag;

  int errors = 0;
  int checks = 0;

  // Model state: the result slot contents and who wins the next tie.
  logic             m_valid;
  logic [31:0]      m_y;
  logic [TAG_W-1:0] m_tag;
  logic             m_src, m_err;
  int               m_ptr;

  always #5 clk = ~clk;

  alu_issue_arbiter #(.TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_f(req0_f),
    .req0_shamt(req0_shamt), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_f(req1_f),
    .req1_shamt(req1_shamt), .req1_tag(req1_tag),
    .res_valid(res_valid), .res_ready(res_ready), .res_y(res_y),
    .res_tag(res_tag), .res_src(res_src), .res_err(res_err)
  );

  function automatic logic [32:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] f, input logic [4:0] sh);
    logic [31:0] d;
    d = a - b;
    case (f)
      4'b0000: return {1'b0, a & b};
      4'b0001: return {1'b0, a | b};
      4'b0010: return {1'b0, a + b};
      4'b1010: return {1'b0, d};
      4'b1011: return {1'b0, 31'd0, d[31]};
      4'b0100: return {1'b0, b << sh};
      default: return {1'b1, 32'd0};
    endcase
  endfunction

  // Which slot the rules grant this cycle, or -1 for none.
  function automatic int model_grant();
    if (reset) return -1;
    if (m_valid && !res_ready) return -1;
    if (req0_valid && req1_valid) return m_ptr;
    if (req0_valid) return 0;
    if (req1_valid) return 1;
    return -1;
  endfunction

  task automatic tick();
    int g;
    logic [32:0] r;
    g = model_grant();
    if (g == 0) r = ref_alu(req0_a, req0_b, req0_f, req0_shamt);
    else        r = ref_alu(req1_a, req1_b, req1_f, req1_shamt);
    @(posedge clk);
    if (reset) begin
      m_valid = 1'b0; m_y = '0; m_tag = '0; m_src = 1'b0; m_err = 1'b0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_y     = r[31:0];
      m_err   = r[32];
      m_tag   = (g == 0) ? req0_tag : req1_tag;
      m_src   = (g == 1);
      m_ptr   = 1 - g;
    end else if (m_valid && res_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic set_op0(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic [4:0] sh, input logic [TAG_W-1:0] t);
    req0_valid = v; req0_a = a; req0_b = b; req0_f = f; req0_shamt = sh; req0_tag = t;
  endtask

  task automatic set_op1(input logic v, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] f, input logic [4:0] sh, input logic [TAG_W-1:0] t);
    req1_valid = v; req1_a = a; req1_b = b; req1_f = f; req1_shamt = sh; req1_tag = t;
  endtask

  function automatic logic [3:0] rand_f();
    logic [3:0] legal [6];
    legal[0] = 4'b0000; legal[1] = 4'b0001; legal[2] = 4'b0010;
    legal[3] = 4'b1010; legal[4] = 4'b1011; legal[5] = 4'b0100;
    if ($urandom_range(0, 4) == 0) return 4'($urandom);
    return legal[$urandom_range(0, 5)];
  endfunction

  task automatic test_reset();
    reset = 1'b1; res_ready = 1'b0;
    set_op0(1'b1, 32'd1, 32'd2, 4'b0010, 5'd0, 4'd1);
    set_op1(1'b1, 32'd3, 32'd4, 4'b0010, 5'd0, 4'd2);
    tick(); tick();
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready: got %b%b want 00", req0_ready, req1_ready);
    end
    checks++;
    if ({res_valid, res_y, res_tag, res_src, res_err} !== {1'b0, 32'd0, 4'd0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_res: got v=%b y=%h tag=%h src=%b err=%b want all zero",
               res_valid, res_y, res_tag, res_src, res_err);
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    res_ready = 1'b1;
    set_op0(1'b1, 32'd5, 32'd7, 4'b0010, 5'd0, 4'd3);
    set_op1(1'b0, 32'd0, 32'd0, 4'b0000, 5'd0, 4'd0);
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL single_ready: got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0;
    checks++;
    if ({res_valid, res_y, res_tag, res_src, res_err} !== {1'b1, 32'd12, 4'd3, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL single_res: got v=%b y=%0d tag=%0d src=%b err=%b want v=1 y=12 tag=3 src=0 err=0",
               res_valid, res_y, res_tag, res_src, res_err);
    end
    tick();
    checks++;
    if (res_valid !== 1'b0) begin
      errors++; $display("FAIL single_drain: got res_valid=%b want 0", res_valid);
    end
  endtask

  task automatic test_alternate();
    reset = 1'b1; tick(); reset = 1'b0;
    res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_op0(1'b1, $urandom, $urandom, 4'b0010, 5'd0, 4'(i));
      set_op1(1'b1, $urandom, $urandom, 4'b0001, 5'd0, 4'(i + 8));
      #1;
      checks++;
      if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
        errors++;
        $display("FAIL alternate_grant[%0d]: got %b%b want slot %0d", i, req0_ready, req1_ready, i % 2);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_src !== 1'(i % 2) || res_y !== m_y || res_tag !== m_tag) begin
        errors++;
        $display("FAIL alternate_res[%0d]: got v=%b src=%b y=%h tag=%h want v=1 src=%0d y=%h tag=%h",
                 i, res_valid, res_src, res_y, res_tag, i % 2, m_y, m_tag);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] y_hold;
    logic [TAG_W-1:0] t_hold;
    logic s_hold;
    y_hold = res_y; t_hold = res_tag; s_hold = res_src;
    res_ready = 1'b0;
    set_op0(1'b1, 32'd100, 32'd1, 4'b1010, 5'd0, 4'd5);
    set_op1(1'b1, 32'd200, 32'd2, 4'b1010, 5'd0, 4'd6);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        errors++; $display("FAIL hold_ready[%0d]: got %b%b want 00", i, req0_ready, req1_ready);
      end
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_y !== y_hold || res_tag !== t_hold || res_src !== s_hold) begin
        errors++;
        $display("FAIL hold_res[%0d]: got v=%b y=%h tag=%h src=%b want v=1 y=%h tag=%h src=%b",
                 i, res_valid, res_y, res_tag, res_src, y_hold, t_hold, s_hold);
      end
    end
    // After six alternating grants slot 0 holds the tie-break.
    res_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL release_ready: got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    checks++;
    if (res_valid !== 1'b1 || res_y !== 32'd99 || res_tag !== 4'd5 || res_src !== 1'b0) begin
      errors++;
      $display("FAIL release_res: got v=%b y=%0d tag=%0d src=%b want v=1 y=99 tag=5 src=0",
               res_valid, res_y, res_tag, res_src);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_alu_sweep();
    logic [31:0] va [8], vb [8], vy [8];
    logic [3:0]  vf [8];
    logic [4:0]  vs [8];
    logic        ve [8];
    va[0] = 32'd3;        vb[0] = 32'd5; vf[0] = 4'b1010; vs[0] = 5'd0;  vy[0] = 32'hFFFFFFFE; ve[0] = 1'b0;
    va[1] = 32'd3;        vb[1] = 32'd5; vf[1] = 4'b1011; vs[1] = 5'd0;  vy[1] = 32'd1;        ve[1] = 1'b0;
    va[2] = 32'd5;        vb[2] = 32'd3; vf[2] = 4'b1011; vs[2] = 5'd0;  vy[2] = 32'd0;        ve[2] = 1'b0;
    va[3] = 32'd0;        vb[3] = 32'd1; vf[3] = 4'b0100; vs[3] = 5'd31; vy[3] = 32'h80000000; ve[3] = 1'b0;
    va[4] = 32'd9;        vb[4] = 32'd9; vf[4] = 4'b0111; vs[4] = 5'd0;  vy[4] = 32'd0;        ve[4] = 1'b1;
    va[5] = 32'hFFFFFFFF; vb[5] = 32'd1; vf[5] = 4'b0010; vs[5] = 5'd0;  vy[5] = 32'd0;        ve[5] = 1'b0;
    va[6] = 32'hF0F0FF00; vb[6] = 32'h0FF0F0F0; vf[6] = 4'b0000; vs[6] = 5'd0; vy[6] = 32'h00F0F000; ve[6] = 1'b0;
    va[7] = 32'hF0F0FF00; vb[7] = 32'h0FF0F0F0; vf[7] = 4'b0001; vs[7] = 5'd0; vy[7] = 32'hFFF0FFF0; ve[7] = 1'b0;
    res_ready = 1'b1;
    req1_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_op0(1'b1, va[i], vb[i], vf[i], vs[i], 4'(i));
      tick();
      checks++;
      if (res_valid !== 1'b1 || res_y !== vy[i] || res_err !== ve[i] || res_tag !== 4'(i)) begin
        errors++;
        $display("FAIL sweep[%0d] f=%b: got v=%b y=%h err=%b tag=%0d want v=1 y=%h err=%b tag=%0d",
                 i, vf[i], res_valid, res_y, res_err, res_tag, vy[i], ve[i], i);
      end
    end
    req0_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset_midflight();
    // Slot 0 alone wins, leaving the tie-break on slot 1 before reset.
    res_ready = 1'b1;
    set_op0(1'b1, 32'd1, 32'd1, 4'b0010, 5'd0, 4'd1);
    req1_valid = 1'b0;
    tick();
    res_ready = 1'b0;
    req1_valid = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (res_valid !== 1'b0 || req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      errors++;
      $display("FAIL midreset: got res_valid=%b ready=%b%b want 0 00", res_valid, req0_ready, req1_ready);
    end
    reset = 1'b0;
    res_ready = 1'b1;
    #1;
    checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      errors++; $display("FAIL midreset_ptr: got %b%b want 10", req0_ready, req1_ready);
    end
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    int g;
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 59) == 0);
      res_ready = ($urandom_range(0, 3) != 0);
      set_op0(1'($urandom_range(0, 3) != 0), $urandom, $urandom, rand_f(), 5'($urandom), 4'($urandom));
      set_op1(1'($urandom_range(0, 3) != 0), $urandom, $urandom, rand_f(), 5'($urandom), 4'($urandom));
      #1;
      g = model_grant();
      checks++;
      if (req0_ready !== (g == 0) || req1_ready !== (g == 1)) begin
        errors++; $display("FAIL rand_ready[%0d]: got %b%b want grant %0d", i, req0_ready, req1_ready, g);
      end
      tick();
      checks++;
      if (res_valid !== m_valid ||
          (m_valid && {res_y, res_tag, res_src, res_err} !== {m_y, m_tag, m_src, m_err})) begin
        errors++;
        $display("FAIL rand_res[%0d]: got v=%b y=%h tag=%h src=%b err=%b want v=%b y=%h tag=%h src=%b err=%b",
                 i, res_valid, res_y, res_tag, res_src, res_err, m_valid, m_y, m_tag, m_src, m_err);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    m_valid = 1'b0; m_y = '0; m_tag = '0; m_src = 1'b0; m_err = 1'b0; m_ptr = 0;
    @(negedge clk);
    test_reset();
    test_single();
    test_alternate();
    test_backpressure();
    test_alu_sweep();
    test_reset_midflight();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
